// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg
// Shared definitions for the 24Cxx EEPROM transaction sequencer: FSM state
// encoding, error codes, the 24Cxx device type code and the device-select
// byte builder.
package i2c_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DSW,
        ST_ADDR,
        ST_DSR,
        ST_RDATA,
        ST_WDATA,
        ST_POLL,
        ST_STOP,
        ST_FIN
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_DEVSEL = 2'd1;
    localparam logic [1:0] ERR_NACK   = 2'd2;
    localparam logic [1:0] ERR_POLL   = 2'd3;

    localparam logic [3:0] DEV_TYPE = 4'b1010;

    // rw: 1 = read, 0 = write
    function automatic logic [7:0] dev_byte(input logic [2:0] devsel, input logic rw);
        return {DEV_TYPE, devsel, rw};
    endfunction

endpackage

// File: rtl/i2c_seq_buffer.sv
// i2c_seq_buffer
// 16x8 staging buffer between host and sequencer.
// Ports:
//   clock, reset             : clock, synchronous active-high reset (read register only)
//   seq_we/seq_idx/seq_wdata : sequencer write port
//   seq_rdata                : combinational read at seq_idx (write-data source)
//   host_we/host_addr/host_wdata : host write port
//   host_rdata               : registered host read at host_addr, 1-cycle latency
module i2c_seq_buffer (
    input  logic       clock,
    input  logic       reset,
    input  logic       seq_we,
    input  logic [3:0] seq_idx,
    input  logic [7:0] seq_wdata,
    output logic [7:0] seq_rdata,
    input  logic       host_we,
    input  logic [3:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata
);

    logic [7:0] mem [16];

    // Contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (seq_we) begin
            mem[seq_idx] <= seq_wdata;
        end else if (host_we) begin
            mem[host_addr] <= host_wdata;
        end
    end

    // A sequencer write to the index being read is forwarded so the new
    // byte appears on the next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            host_rdata <= '0;
        end else if (seq_we && (seq_idx == host_addr)) begin
            host_rdata <= seq_wdata;
        end else begin
            host_rdata <= mem[host_addr];
        end
    end

    assign seq_rdata = mem[seq_idx];

endmodule

// File: rtl/i2c_eeprom_sequencer.sv
// i2c_eeprom_sequencer
// Sequences the I2C byte engine through a complete 24Cxx random read or page
// write (1-16 bytes) from a single host command, with optional ACK polling.
// Configuration macro: I2C_SEQ_ACKPOLL_EN enables ACK polling after writes.
// Ports:
//   clock, reset                     : clock, synchronous active-high reset
//   cmd_valid/cmd_ready              : command handshake (ready only in IDLE)
//   cmd_read/cmd_devsel/cmd_addr/cmd_len : command fields (len = bytes-1)
//   buf_we/buf_addr/buf_wdata/buf_rdata  : host buffer access
//   busy/done/err/err_code           : transaction status
//   eng_go/eng_start/eng_stop/eng_read/eng_ack/eng_byte : engine op request
//   eng_done/eng_nack/eng_rbyte      : engine op completion
// POLL_MAX must be at least 1.
module i2c_eeprom_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned POLL_MAX = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_read,
    input  logic [2:0] cmd_devsel,
    input  logic [7:0] cmd_addr,
    input  logic [3:0] cmd_len,
    input  logic       buf_we,
    input  logic [3:0] buf_addr,
    input  logic [7:0] buf_wdata,
    output logic [7:0] buf_rdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic       eng_go,
    output logic       eng_start,
    output logic       eng_stop,
    output logic       eng_read,
    output logic       eng_ack,
    output logic [7:0] eng_byte,
    input  logic       eng_done,
    input  logic       eng_nack,
    input  logic [7:0] eng_rbyte
);

`ifdef I2C_SEQ_ACKPOLL_EN
    localparam bit ACKPOLL = 1'b1;
`else
    localparam bit ACKPOLL = 1'b0;
`endif
    localparam int unsigned PW = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX);

    state_t          state_q, state_d;
    logic            go_q, go_d;
    logic [3:0]      idx_q, idx_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic [1:0]      code_q, code_d;
    logic            rd_q;
    logic [2:0]      devsel_q;
    logic [7:0]      addr_q;
    logic [3:0]      len_q;
    logic            accept, ev, last, seq_we;
    logic [7:0]      seq_rdata;

    i2c_seq_buffer u_buf (
        .clock      (clock),
        .reset      (reset),
        .seq_we     (seq_we),
        .seq_idx    (idx_q),
        .seq_wdata  (eng_rbyte),
        .seq_rdata  (seq_rdata),
        .host_we    (buf_we && (state_q == ST_IDLE)),
        .host_addr  (buf_addr),
        .host_wdata (buf_wdata),
        .host_rdata (buf_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            go_q     <= 1'b0;
            idx_q    <= '0;
            poll_q   <= '0;
            code_q   <= ERR_NONE;
            rd_q     <= 1'b0;
            devsel_q <= '0;
            addr_q   <= '0;
            len_q    <= '0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            idx_q   <= idx_d;
            poll_q  <= poll_d;
            code_q  <= code_d;
            if (accept) begin
                rd_q     <= cmd_read;
                devsel_q <= cmd_devsel;
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
            end
        end
    end

    // Counters only step while below their limit, so they cannot wrap.
    always_comb begin
        state_d = state_q;
        go_d    = 1'b0;
        idx_d   = idx_q;
        poll_d  = poll_q;
        code_d  = code_q;
        accept  = 1'b0;
        seq_we  = 1'b0;
        ev      = eng_done && !go_q;
        last    = (idx_q == len_q);
        case (state_q)
            ST_IDLE: if (cmd_valid) begin
                accept  = 1'b1;
                state_d = ST_DSW;
                go_d    = 1'b1;
                idx_d   = '0;
                poll_d  = '0;
                code_d  = ERR_NONE;
            end
            ST_DSW, ST_DSR: if (ev) begin
                go_d = 1'b1;
                if (eng_nack) begin
                    code_d  = ERR_DEVSEL;
                    state_d = ST_STOP;
                end else begin
                    state_d = (state_q == ST_DSW) ? ST_ADDR : ST_RDATA;
                end
            end
            ST_ADDR: if (ev) begin
                go_d = 1'b1;
                if (eng_nack) begin
                    code_d  = ERR_NACK;
                    state_d = ST_STOP;
                end else begin
                    state_d = rd_q ? ST_DSR : ST_WDATA;
                end
            end
            ST_RDATA: if (ev) begin
                seq_we = 1'b1;
                if (last) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d = idx_q + 4'd1;
                    go_d  = 1'b1;
                end
            end
            ST_WDATA: if (ev) begin
                if (eng_nack) begin
                    code_d  = ERR_NACK;
                    state_d = ST_STOP;
                    go_d    = 1'b1;
                end else if (last) begin
                    state_d = ACKPOLL ? ST_POLL : ST_FIN;
                    go_d    = ACKPOLL;
                end else begin
                    idx_d = idx_q + 4'd1;
                    go_d  = 1'b1;
                end
            end
            ST_POLL: if (ev) begin
                if (!eng_nack) begin
                    state_d = ST_FIN;
                end else if (poll_q == PW'(POLL_MAX - 1)) begin
                    code_d  = ERR_POLL;
                    state_d = ST_FIN;
                end else begin
                    poll_d = poll_q + PW'(1);
                    go_d   = 1'b1;
                end
            end
            ST_STOP: if (ev) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Engine fields depend only on registered state, so they hold from
    // eng_go until eng_done without extra staging registers.
    always_comb begin
        eng_start = 1'b0;
        eng_stop  = 1'b0;
        eng_read  = 1'b0;
        eng_ack   = 1'b0;
        eng_byte  = '0;
        case (state_q)
            ST_DSW: begin
                eng_start = 1'b1;
                eng_ack   = 1'b1;
                eng_byte  = dev_byte(devsel_q, 1'b0);
            end
            ST_ADDR: begin
                eng_ack  = 1'b1;
                eng_byte = addr_q;
            end
            ST_DSR: begin
                eng_start = 1'b1;
                eng_ack   = 1'b1;
                eng_byte  = dev_byte(devsel_q, 1'b1);
            end
            ST_RDATA: begin
                eng_read = 1'b1;
                eng_ack  = !last;
                eng_stop = last;
            end
            ST_WDATA: begin
                eng_ack  = 1'b1;
                eng_stop = last;
                eng_byte = seq_rdata;
            end
            ST_POLL: begin
                eng_start = 1'b1;
                eng_stop  = 1'b1;
                eng_ack   = 1'b1;
                eng_byte  = dev_byte(devsel_q, 1'b0);
            end
            ST_STOP: eng_stop = 1'b1;
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign err       = (code_q != ERR_NONE);
    assign err_code  = code_q;
    assign eng_go    = go_q;

endmodule
